// File: rtl/game_types.sv
// Shared types and defaults for the digit-guessing game controller.
package game_types;

  localparam int unsigned DIGIT_W          = 4;
  localparam int unsigned CHANCE_W         = 3;
  localparam int unsigned MAX_CHANCES_DEF  = 5;
  localparam int unsigned RESULT_TICKS_DEF = 150_000_000;

  typedef logic [3:0][DIGIT_W-1:0] digits_t;

  typedef enum logic [3:0] {
    S_IDLE,
    S_SET_D3,
    S_SET_D2,
    S_SET_D1,
    S_SET_D0,
    S_GUESS_D3,
    S_GUESS_D2,
    S_GUESS_D1,
    S_GUESS_D0,
    S_SHOW_RESULT,
    S_WIN,
    S_LOSE
  } state_t;

  // Digit position a SET/GUESS state is waiting for; 0 for every other state.
  function automatic logic [1:0] slot_of(state_t s);
    case (s)
      S_SET_D3, S_GUESS_D3: return 2'd3;
      S_SET_D2, S_GUESS_D2: return 2'd2;
      S_SET_D1, S_GUESS_D1: return 2'd1;
      default:              return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/game_fsm_if.sv
// Key/switch inputs and game status outputs of game_fsm.
interface game_fsm_if;
  import game_types::*;

  logic                   key_confirm;
  logic                   key_restart;
  logic [DIGIT_W-1:0]     sw;
  state_t                 state;
  digits_t                target;
  digits_t                guess;
  logic [DIGIT_W-1:0]     candidate;
  logic                   sw_valid;
  logic [CHANCE_W-1:0]    chances;

  modport master (
    output key_confirm, key_restart, sw,
    input  state, target, guess, candidate, sw_valid, chances
  );

  modport slave (
    input  key_confirm, key_restart, sw,
    output state, target, guess, candidate, sw_valid, chances
  );
endinterface

// File: rtl/digit_checker.sv
// Accepts a switch value when it is a decimal digit not already used in higher slots.
module digit_checker
  import game_types::*;
(
  input  logic [DIGIT_W-1:0]          sw_i,
  input  logic [2:0][DIGIT_W-1:0]     prior_i,   // [2]=digit 3, [1]=digit 2, [0]=digit 1
  input  logic [1:0]                  slot_i,
  output logic                        valid_o
);

  logic [2:0] dup;

  // Only digits above the current slot have been entered in this phase.
  assign dup[0] = (slot_i == 2'd0) && (sw_i == prior_i[0]);
  assign dup[1] = (slot_i <= 2'd1) && (sw_i == prior_i[1]);
  assign dup[2] = (slot_i <= 2'd2) && (sw_i == prior_i[2]);

  assign valid_o = (sw_i <= DIGIT_W'(9)) && (dup == 3'b000);

endmodule

// File: rtl/game_fsm.sv
// Four-digit guessing game: secret entry, guessing with limited chances, result dwell.
module game_fsm
  import game_types::*;
#(
  parameter int unsigned RESULT_TICKS = RESULT_TICKS_DEF,
  parameter int unsigned MAX_CHANCES  = MAX_CHANCES_DEF
) (
  input  logic         clk,
  input  logic         rst,
  game_fsm_if.slave    bus
);

  localparam int unsigned CNT_W = (RESULT_TICKS > 1) ? $clog2(RESULT_TICKS) : 1;

  state_t                state_q;
  digits_t               target_q;
  digits_t               guess_q;
  logic [CHANCE_W-1:0]   chances_q;
  logic [CNT_W-1:0]      dwell_q;

  logic                  in_set_c;
  logic                  in_guess_c;
  logic [1:0]            slot_c;
  digits_t               entered_c;
  logic                  chk_valid_c;
  logic                  sw_valid_c;
  logic                  accept_c;
  logic                  win_c;
  logic                  dwell_done_c;

  assign in_set_c   = (state_q == S_SET_D3)   || (state_q == S_SET_D2) ||
                      (state_q == S_SET_D1)   || (state_q == S_SET_D0);
  assign in_guess_c = (state_q == S_GUESS_D3) || (state_q == S_GUESS_D2) ||
                      (state_q == S_GUESS_D1) || (state_q == S_GUESS_D0);
  assign slot_c     = slot_of(state_q);
  assign entered_c  = in_set_c ? target_q : guess_q;

  digit_checker u_checker (
    .sw_i    (bus.sw),
    .prior_i (entered_c[3:1]),
    .slot_i  (slot_c),
    .valid_o (chk_valid_c)
  );

  assign sw_valid_c   = (in_set_c || in_guess_c) && chk_valid_c;
  assign accept_c     = bus.key_confirm && sw_valid_c;
  // Final compare uses the digit being confirmed, not the stale guess[0].
  assign win_c        = ({guess_q[3:1], bus.sw} == target_q);
  assign dwell_done_c = (dwell_q == CNT_W'(RESULT_TICKS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      target_q  <= '0;
      guess_q   <= '0;
      chances_q <= '0;
      dwell_q   <= '0;
    end else if (bus.key_restart) begin
      state_q <= S_IDLE;
      dwell_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (bus.key_confirm) state_q <= S_SET_D3;

        S_SET_D3: if (accept_c) begin target_q[3] <= bus.sw; state_q <= S_SET_D2; end
        S_SET_D2: if (accept_c) begin target_q[2] <= bus.sw; state_q <= S_SET_D1; end
        S_SET_D1: if (accept_c) begin target_q[1] <= bus.sw; state_q <= S_SET_D0; end
        S_SET_D0: if (accept_c) begin
          target_q[0] <= bus.sw;
          chances_q   <= CHANCE_W'(MAX_CHANCES);
          state_q     <= S_GUESS_D3;
        end

        S_GUESS_D3: if (accept_c) begin guess_q[3] <= bus.sw; state_q <= S_GUESS_D2; end
        S_GUESS_D2: if (accept_c) begin guess_q[2] <= bus.sw; state_q <= S_GUESS_D1; end
        S_GUESS_D1: if (accept_c) begin guess_q[1] <= bus.sw; state_q <= S_GUESS_D0; end
        S_GUESS_D0: if (accept_c) begin
          guess_q[0] <= bus.sw;
          if (win_c) begin
            state_q <= S_WIN;
          end else begin
            state_q   <= S_SHOW_RESULT;
            chances_q <= (chances_q == '0) ? '0 : chances_q - CHANCE_W'(1);
            dwell_q   <= '0;
          end
        end

        // Confirm and timeout together still make a single advance.
        S_SHOW_RESULT: begin
          dwell_q <= dwell_q + CNT_W'(1);
          if (bus.key_confirm || dwell_done_c)
            state_q <= (chances_q == '0) ? S_LOSE : S_GUESS_D3;
        end

        S_WIN, S_LOSE: if (bus.key_confirm) state_q <= S_IDLE;

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.state     = state_q;
  assign bus.target    = target_q;
  assign bus.guess     = guess_q;
  assign bus.chances   = chances_q;
  assign bus.candidate = bus.sw;
  assign bus.sw_valid  = sw_valid_c;

endmodule

// File: tb/tb_game_fsm.sv
// Self-checking bench for game_fsm: phase-level model plus directed scenarios.
module tb_game_fsm;
  import game_types::*;

  localparam int unsigned TICKS = 16;
  localparam int unsigned MAXC  = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  game_fsm_if bus();

  game_fsm #(.RESULT_TICKS(TICKS), .MAX_CHANCES(MAXC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // ---------------- model: game phase + slot, digits as plain ints ----------------
  typedef enum {P_IDLE, P_SET, P_GUESS, P_SHOW, P_WIN, P_LOSE} phase_e;
  phase_e m_phase = P_IDLE;
  int     m_slot  = 3;
  int     m_tgt[4] = '{0, 0, 0, 0};
  int     m_gs[4]  = '{0, 0, 0, 0};
  int     m_ch    = 0;
  int     m_dwell = 0;

  function automatic state_t m_state();
    state_t set_s[4]   = '{S_SET_D0, S_SET_D1, S_SET_D2, S_SET_D3};
    state_t guess_s[4] = '{S_GUESS_D0, S_GUESS_D1, S_GUESS_D2, S_GUESS_D3};
    case (m_phase)
      P_SET:   return set_s[m_slot];
      P_GUESS: return guess_s[m_slot];
      P_SHOW:  return S_SHOW_RESULT;
      P_WIN:   return S_WIN;
      P_LOSE:  return S_LOSE;
      default: return S_IDLE;
    endcase
  endfunction

  function automatic bit m_valid(int v);
    if (m_phase != P_SET && m_phase != P_GUESS) return 1'b0;
    if (v > 9) return 1'b0;
    for (int k = 3; k > m_slot; k--) begin
      if ((m_phase == P_SET ? m_tgt[k] : m_gs[k]) == v) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic logic [15:0] pack4(int d3, int d2, int d1, int d0);
    return {4'(d3), 4'(d2), 4'(d1), 4'(d0)};
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase = P_IDLE; m_slot = 3; m_ch = 0; m_dwell = 0;
      m_tgt = '{0, 0, 0, 0}; m_gs = '{0, 0, 0, 0};
    end else if (bus.key_restart) begin
      m_phase = P_IDLE; m_dwell = 0;
    end else begin
      int v;
      bit ok;
      v  = int'(bus.sw);
      ok = bus.key_confirm && m_valid(v);
      case (m_phase)
        P_IDLE: if (bus.key_confirm) begin m_phase = P_SET; m_slot = 3; end
        P_SET: if (ok) begin
          m_tgt[m_slot] = v;
          if (m_slot == 0) begin m_phase = P_GUESS; m_slot = 3; m_ch = MAXC; end
          else m_slot--;
        end
        P_GUESS: if (ok) begin
          m_gs[m_slot] = v;
          if (m_slot > 0) m_slot--;
          else if (m_gs == m_tgt) m_phase = P_WIN;
          else begin
            m_phase = P_SHOW; m_dwell = 0;
            if (m_ch > 0) m_ch--;
          end
        end
        P_SHOW: begin
          m_dwell++;
          if (bus.key_confirm || m_dwell == TICKS) begin
            m_phase = (m_ch == 0) ? P_LOSE : P_GUESS;
            m_slot  = 3;
          end
        end
        P_WIN, P_LOSE: if (bus.key_confirm) m_phase = P_IDLE;
        default: m_phase = P_IDLE;
      endcase
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    logic [15:0] et, eg;
    et = pack4(m_tgt[3], m_tgt[2], m_tgt[1], m_tgt[0]);
    eg = pack4(m_gs[3], m_gs[2], m_gs[1], m_gs[0]);
    n_checks++;
    if (bus.state !== m_state() || bus.target !== et || bus.guess !== eg ||
        bus.chances !== 3'(m_ch) || bus.candidate !== bus.sw ||
        bus.sw_valid !== m_valid(int'(bus.sw))) begin
      n_errors++;
      $display("FAIL model_cmp t=%0t state=%0d/%0d target=%h/%h guess=%h/%h chances=%0d/%0d sw_valid=%b/%b cand=%h/%h",
               $time, bus.state, m_state(), bus.target, et, bus.guess, eg,
               bus.chances, m_ch, bus.sw_valid, m_valid(int'(bus.sw)), bus.candidate, bus.sw);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_sw(int v);
    bus.sw = 4'(v);
    #1;
  endtask

  task automatic press(int v);
    bus.sw = 4'(v);
    bus.key_confirm = 1'b1;
    tick();
    bus.key_confirm = 1'b0;
  endtask

  task automatic restart();
    bus.key_restart = 1'b1;
    tick();
    bus.key_restart = 1'b0;
  endtask

  task automatic enter4(int a, int b, int c, int d);
    press(a); press(b); press(c); press(d);
  endtask

  task automatic wait_dwell(output int n);
    n = 0;
    while (bus.state == S_SHOW_RESULT && n < 40) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int n;
    bus.key_confirm = 1'b0;
    bus.key_restart = 1'b0;
    bus.sw          = 4'd0;
    repeat (2) tick();
    chk("rst_state",   32'(bus.state),   32'(S_IDLE));
    chk("rst_target",  32'(bus.target),  32'h0);
    chk("rst_chances", 32'(bus.chances), 32'd0);
    rst = 1'b0;
    tick();

    // Win path: target 1234, guess 1234.
    press(0);
    chk("idle_to_set", 32'(bus.state), 32'(S_SET_D3));
    enter4(1, 2, 3, 4);
    chk("set_done_state", 32'(bus.state),   32'(S_GUESS_D3));
    chk("set_done_ch",    32'(bus.chances), 32'd5);
    enter4(1, 2, 3, 4);
    chk("win_state",   32'(bus.state),   32'(S_WIN));
    chk("win_chances", 32'(bus.chances), 32'd5);
    chk("win_guess",   32'(bus.guess),   32'h1234);
    press(0);
    chk("win_to_idle", 32'(bus.state),  32'(S_IDLE));
    chk("idle_target", 32'(bus.target), 32'h1234);

    // Rejected entries in S_SET_D2 after target[3]=7.
    press(0); press(7);
    chk("set_d2", 32'(bus.state), 32'(S_SET_D2));
    set_sw(7);
    chk("dup_invalid", 32'(bus.sw_valid), 32'd0);
    press(7);
    chk("dup_ignored", 32'(bus.state), 32'(S_SET_D2));
    set_sw(12);
    chk("gt9_invalid", 32'(bus.sw_valid), 32'd0);
    press(12);
    chk("gt9_ignored", 32'(bus.state), 32'(S_SET_D2));
    set_sw(3);
    chk("ok_valid", 32'(bus.sw_valid), 32'd1);
    press(3);
    chk("set_d1", 32'(bus.state), 32'(S_SET_D1));
    chk("partial_target", 32'(bus.target[3:2]), 32'h73);
    restart();

    // Five wrong guesses advanced by timeout.
    press(0);
    enter4(1, 2, 3, 4);
    for (int i = 0; i < 5; i++) begin
      enter4(5, 6, 7, 8);
      chk("show_state", 32'(bus.state),   32'(S_SHOW_RESULT));
      chk("show_ch",    32'(bus.chances), 32'(4 - i));
      wait_dwell(n);
      chk("dwell_len", 32'(n), 32'(TICKS));
      chk("after_dwell", 32'(bus.state), (i == 4) ? 32'(S_LOSE) : 32'(S_GUESS_D3));
    end
    press(0);
    chk("lose_to_idle", 32'(bus.state),   32'(S_IDLE));
    chk("lose_ch_hold", 32'(bus.chances), 32'd0);

    // Restart wins over confirm in S_GUESS_D1.
    press(0);
    enter4(1, 2, 3, 4);
    press(9); press(8);
    chk("guess_d1", 32'(bus.state), 32'(S_GUESS_D1));
    bus.sw = 4'd7;
    bus.key_confirm = 1'b1;
    bus.key_restart = 1'b1;
    tick();
    bus.key_confirm = 1'b0;
    bus.key_restart = 1'b0;
    chk("restart_prio", 32'(bus.state),       32'(S_IDLE));
    chk("restart_gs",   32'(bus.guess[3:2]),  32'h98);

    // Confirm coinciding with the final dwell tick.
    press(0);
    enter4(1, 2, 3, 4);
    enter4(5, 6, 7, 8);
    repeat (TICKS - 1) tick();
    chk("pre_timeout", 32'(bus.state), 32'(S_SHOW_RESULT));
    press(0);
    chk("single_adv",  32'(bus.state),   32'(S_GUESS_D3));
    chk("adv_ch",      32'(bus.chances), 32'd4);
    repeat (3) tick();
    chk("no_double",   32'(bus.state),   32'(S_GUESS_D3));

    // Asynchronous reset pulse inside S_SHOW_RESULT.
    enter4(5, 6, 7, 8);
    tick(); tick();
    chk("pre_rst", 32'(bus.state), 32'(S_SHOW_RESULT));
    #2 rst = 1'b1;
    #1;
    chk("async_state",   32'(bus.state),   32'(S_IDLE));
    chk("async_target",  32'(bus.target),  32'h0);
    chk("async_guess",   32'(bus.guess),   32'h0);
    chk("async_chances", 32'(bus.chances), 32'd0);
    #2 rst = 1'b0;
    tick();
    press(0);
    chk("post_rst_confirm", 32'(bus.state), 32'(S_SET_D3));
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/game_fsm.md
GAME_FSM -- requirements
Module: game_fsm

Interface
REQ-001 SHALL have parameter RESULT_TICKS, default 150_000_000, giving the clk cycles S_SHOW_RESULT dwells before auto-advance (3 s at 50 MHz).
REQ-002 SHALL have parameter MAX_CHANCES, default 5, giving the chances loaded at start of guessing; legal range 1-7.
REQ-003 SHALL have port clk, input, 1, system clock; one clock; reset is asynchronous and active-high.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port key_confirm, input, 1, debounced single-cycle confirm pulse.
REQ-006 SHALL have port key_restart, input, 1, debounced single-cycle restart pulse.
REQ-007 SHALL have port sw, input, 4, digit switches.
REQ-008 SHALL have port state, output, state_t, current game state.
REQ-009 SHALL have port target, output, 4x4, secret digits [3:0], [3] leftmost.
REQ-010 SHALL have port guess, output, 4x4, guessed digits [3:0].
REQ-011 SHALL have port candidate, output, 4, equal to sw, combinational.
REQ-012 SHALL have port sw_valid, output, 1, candidate acceptable for the current slot, combinational.
REQ-013 SHALL have port chances, output, 3, remaining guesses.

Function
REQ-014 SHALL use states S_IDLE, S_SET_D3..S_SET_D0, S_GUESS_D3..S_GUESS_D0, S_SHOW_RESULT, S_WIN and S_LOSE.
REQ-015 SHALL drive sw_valid=1 only in SET/GUESS states, and only when sw<=9 and sw differs from every digit already entered in the current phase (SET_Dn: target[3..n+1]; GUESS_Dn: guess[3..n+1]); sw_valid=0 in all other states.
REQ-016 SHALL, in S_IDLE on key_confirm, go to S_SET_D3.
REQ-017 SHALL, in S_SET_Dn on key_confirm with sw_valid=1, latch target[n]<=sw and advance to S_SET_D(n-1).
REQ-018 SHALL, in S_SET_D0 on key_confirm with sw_valid=1, latch target[0], load chances<=MAX_CHANCES and go to S_GUESS_D3.
REQ-019 SHALL ignore key_confirm with sw_valid=0: no state or register change.
REQ-020 SHALL, in S_GUESS_Dn on a valid confirm, latch guess[n]<=sw and advance; in S_GUESS_D0, latch guess[0], then go to S_WIN if all four digits equal target (the compare uses the new guess[0] value, i.e. sw), otherwise go to S_SHOW_RESULT with chances decremented by 1, clear the dwell counter, all in the same cycle.
REQ-021 SHALL, in S_SHOW_RESULT, increment the dwell counter each cycle; on key_confirm or counter==RESULT_TICKS-1 go to S_LOSE if chances==0, else S_GUESS_D3; confirm and timeout in the same cycle SHALL count as one advance.
REQ-022 SHALL hold guess[3:0] unchanged through S_SHOW_RESULT and S_GUESS_D3 until overwritten digit by digit.
REQ-023 SHALL, in S_WIN or S_LOSE on key_confirm, go to S_IDLE; target, guess and chances SHALL hold.
REQ-024 SHALL, on key_restart in any state, go to S_IDLE next cycle, clear the dwell counter and leave target, guess and chances untouched; key_restart SHALL take priority over a simultaneous key_confirm.
REQ-025 SHALL never decrement chances below 0, and SHALL never change chances outside the REQ-018 and REQ-020 events.
REQ-026 SHALL make all state/register updates take effect one clk after the qualifying pulse; candidate and sw_valid have zero latency.

Reset
REQ-027 SHALL, on rst asserted (asynchronous), set state=S_IDLE, target=0,0,0,0, guess=0,0,0,0, chances=0 and dwell counter=0, and SHALL hold these while rst is high.
REQ-028 SHALL, on reset mid-game (any state), discard all progress; the first confirm after release SHALL behave as in S_IDLE.

Structure
REQ-029 SHALL take state_t and the state encodings from the shared package game_types; MAX_CHANCES default and RESULT_TICKS default SHALL be defined as constants in game_types.
REQ-030 SHALL implement the sw_valid uniqueness check as sub-module digit_checker (inputs sw, 3 prior digits, slot index; output valid); the rest stays flat.
REQ-031 SHALL size the dwell counter to $clog2(RESULT_TICKS).

Verification
REQ-032 SHALL verify: set target 1,2,3,4, then guess 1,2,3,4 -> S_WIN one cycle after the last confirm, chances=5.
REQ-033 SHALL verify: in S_SET_D2 after target[3]=7, sw=7 or sw=12 with confirm -> state stays S_SET_D2, sw_valid=0; sw=3 -> S_SET_D1.
REQ-034 SHALL verify: target 1,2,3,4 and five wrong guesses 5,6,7,8, each advanced by timeout (RESULT_TICKS=16) -> chances 4,3,2,1,0 on S_SHOW_RESULT entry, and S_LOSE after the 5th dwell.
REQ-035 SHALL verify: key_confirm and key_restart asserted together in S_GUESS_D1 -> S_IDLE, guess[3:2] retained.
REQ-036 SHALL verify: rst pulsed asynchronously between clk edges in S_SHOW_RESULT -> outputs at reset values before the next edge.
REQ-037 SHALL verify: key_confirm in the same cycle the dwell counter reaches RESULT_TICKS-1 -> a single transition to S_GUESS_D3, chances unchanged.
